// File: rtl/data_mem_ctrl.sv
// Parametrised data memory with registered read, write-first forwarding,
// post-reset clear sweep and out-of-range address detection.
module data_mem_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] aluout_in,
    output logic [DATA_W-1:0] memtoreg_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    state_e state_q, state_d;
    logic [ADDR_W:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] memtoreg_q, memtoreg_d;
    logic rd_valid_q, rd_valid_d;
    logic addr_err_q, addr_err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [IDX_W-1:0]  raddr;
    logic [DATA_W-1:0] wdata;

    assign in_range = {1'b0, address_in} < LIMIT;
    assign raddr    = IDX_W'(address_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST) state_d = IDLE;
            end
            IDLE: state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    // The sweep owns the single write port; requests are dropped until IDLE.
    always_comb begin
        we         = 1'b0;
        waddr      = IDX_W'(clr_ptr_q);
        wdata      = '0;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        memtoreg_d = memtoreg_q;
        unique case (state_q)
            CLEAR: we = ~reset;
            IDLE: begin
                we         = mem_write & in_range & ~reset;
                waddr      = raddr;
                wdata      = aluout_in;
                addr_err_d = (mem_read | mem_write) & ~in_range;
                if (mem_read) begin
                    rd_valid_d = 1'b1;
                    if (!in_range)     memtoreg_d = '0;
                    else if (mem_write) memtoreg_d = aluout_in;
                    else               memtoreg_d = mem[raddr];
                end
            end
            default: we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            memtoreg_q <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            memtoreg_q <= memtoreg_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign memtoreg_out = memtoreg_q;
    assign rd_valid     = rd_valid_q;
    assign addr_err     = addr_err_q;
    assign busy         = (state_q == CLEAR);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: dut a is 8x256 (full address space),
// dut b is 16x200 (out-of-range addresses exist).
module tb_data_mem_ctrl;

    typedef struct {
        logic        rd;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wdat = '0;

    logic [7:0]  a_out;
    logic        a_vld, a_busy, a_err;
    logic [15:0] b_out;
    logic        b_vld, b_busy, b_err;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_a (
        .clk(clk), .reset(rst_a), .mem_read(mem_read),
        .mem_write(mem_write), .address_in(addr),
        .aluout_in(wdat[7:0]), .memtoreg_out(a_out),
        .rd_valid(a_vld), .busy(a_busy), .addr_err(a_err)
    );

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) u_b (
        .clk(clk), .reset(rst_b), .mem_read(mem_read),
        .mem_write(mem_write), .address_in(addr),
        .aluout_in(wdat), .memtoreg_out(b_out),
        .rd_valid(b_vld), .busy(b_busy), .addr_err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per output event.
    always @(negedge clk) begin
        if (a_vld || a_err) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_event", {a_vld, a_err}, 2'b00);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_rd_valid", a_vld, e.rd);
                chk("a_addr_err", a_err, e.err);
                if (e.rd) chk("a_data", a_out, e.data[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (b_vld || b_err) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_event", {b_vld, b_err}, 2'b00);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_rd_valid", b_vld, e.rd);
                chk("b_addr_err", b_err, e.err);
                if (e.rd) chk("b_data", b_out, e.data);
            end
        end
    end

    // One request cycle; expectation goes to the scoreboard of dut sel.
    task automatic op(input bit sel, input logic rd, input logic wr,
                      input logic [7:0] a, input logic [15:0] d,
                      input logic [15:0] exp_d, input logic exp_err);
        exp_t e;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdat      = d;
        e.rd = rd;
        e.data = exp_d;
        e.err = exp_err;
        if (rd || exp_err) begin
            if (sel) qb.push_back(e);
            else qa.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts negedges with busy high after reset release.
    task automatic count_busy(input bit sel, output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ((sel ? b_busy : a_busy) == 1'b0) break;
            n++;
        end
    endtask

    initial begin
        int n;

        // Test 1: reset state and full sweep on dut a.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", a_busy, 1'b1);
        chk("rst_rd_valid", a_vld, 1'b0);
        chk("rst_addr_err", a_err, 1'b0);
        chk("rst_data", a_out, 8'h00);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        count_busy(1'b0, n);
        chk("sweep_len_256", n, 256);
        #1;
        for (int i = 0; i < 256; i++)
            op(1'b0, 1'b1, 1'b0, 8'(i), 16'h0, 16'h0, 1'b0);
        idle(2);

        // Test 2: write then back-to-back reads.
        op(1'b0, 1'b0, 1'b1, 8'h10, 16'h00A5, 16'h0, 1'b0);
        op(1'b0, 1'b0, 1'b1, 8'hFF, 16'h003C, 16'h0, 1'b0);
        op(1'b0, 1'b1, 1'b0, 8'h10, 16'h0, 16'h00A5, 1'b0);
        op(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0, 16'h003C, 1'b0);
        idle(2);
        chk("hold_data", a_out, 8'h3C);

        // Test 3: read-during-write, same and different address.
        op(1'b0, 1'b0, 1'b1, 8'h20, 16'h0011, 16'h0, 1'b0);
        op(1'b0, 1'b1, 1'b1, 8'h20, 16'h0077, 16'h0077, 1'b0);
        op(1'b0, 1'b1, 1'b0, 8'h20, 16'h0, 16'h0077, 1'b0);
        mem_read = 1'b0;
        op(1'b0, 1'b1, 1'b0, 8'h10, 16'h0, 16'h00A5, 1'b0);
        op(1'b0, 1'b0, 1'b1, 8'h30, 16'h005A, 16'h0, 1'b0);
        op(1'b0, 1'b1, 1'b0, 8'h30, 16'h0, 16'h005A, 1'b0);
        idle(2);

        // Test 4: requests during sweep are dropped.
        op(1'b0, 1'b0, 1'b1, 8'h05, 16'h00C3, 16'h0, 1'b0);
        idle(1);
        rst_a = 1'b1;
        idle(1);
        rst_a = 1'b0;
        idle(10);
        mem_read  = 1'b1;
        mem_write = 1'b1;
        addr      = 8'h05;
        wdat      = 16'h0055;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("sweep_no_valid", a_vld, 1'b0);
        chk("sweep_no_err", a_err, 1'b0);
        count_busy(1'b0, n);
        chk("sweep_rest", n, 256 - 12);
        #1;
        op(1'b0, 1'b1, 1'b0, 8'h05, 16'h0, 16'h0000, 1'b0);
        idle(2);
        rst_a = 1'b1;

        // Test 5: out-of-range on dut b (DEPTH=200).
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        count_busy(1'b1, n);
        chk("b_sweep_len", n, 200);
        #1;
        op(1'b1, 1'b0, 1'b1, 8'd5, 16'h1234, 16'h0, 1'b0);
        op(1'b1, 1'b1, 1'b0, 8'd5, 16'h0, 16'h1234, 1'b0);
        op(1'b1, 1'b0, 1'b1, 8'd200, 16'h0099, 16'h0, 1'b1);
        op(1'b1, 1'b1, 1'b0, 8'd200, 16'h0, 16'h0000, 1'b1);
        op(1'b1, 1'b1, 1'b0, 8'd199, 16'h0, 16'h0000, 1'b0);
        op(1'b1, 1'b1, 1'b0, 8'd72, 16'h0, 16'h0000, 1'b0);
        op(1'b1, 1'b1, 1'b0, 8'd255, 16'h0, 16'h0000, 1'b1);
        idle(2);

        // Test 6: mid-sweep reset restarts; 16-bit data path.
        rst_b = 1'b1;
        idle(1);
        rst_b = 1'b0;
        idle(100);
        rst_b = 1'b1;
        idle(1);
        rst_b = 1'b0;
        count_busy(1'b1, n);
        chk("b_restart_len", n, 200);
        #1;
        op(1'b1, 1'b0, 1'b1, 8'd7, 16'hBEEF, 16'h0, 1'b0);
        op(1'b1, 1'b1, 1'b0, 8'd7, 16'h0, 16'hBEEF, 1'b0);
        op(1'b1, 1'b1, 1'b0, 8'd5, 16'h0, 16'h0000, 1'b0);
        idle(3);

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
